// File: rtl/box_filter_7x7_pkg.sv
// Shared constants for the 7x7 box filter: kernel size and the fixed-point
// reciprocal of 49 used to turn the window sum into a rounded mean.
package box_filter_7x7_pkg;
  localparam int KERNEL      = 7;
  localparam int RECIP       = 1337;   // round(65536/49)
  localparam int RECIP_SHIFT = 16;
  localparam int ROUND       = 32768;  // half of 2^RECIP_SHIFT
endpackage

// File: rtl/row_sum_7.sv
// Registered sum of seven pixels: one window row, Datawidth+3 bits wide.
module row_sum_7
  import box_filter_7x7_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic [KERNEL*DW-1:0] px_i,
  output logic [DW+2:0]        sum_o
);
  typedef logic [DW+2:0] sum_t;

  sum_t sum_d, sum_q;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < KERNEL; k++)
      sum_d = sum_d + sum_t'(px_i[k*DW +: DW]);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/box_filter_7x7.sv
// 7x7 box filter: four-stage adder/scaler pipeline producing the rounded
// window mean, with a column counter tagging windows that do not span a row wrap.
module box_filter_7x7
  import box_filter_7x7_pkg::*;
#(
  parameter int IMG_Width = 8,
  parameter int Datawidth = 8
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 Valid_IN,
  input  logic [Datawidth-1:0] R00, R01, R02, R03, R04, R05, R06,
  input  logic [Datawidth-1:0] R10, R11, R12, R13, R14, R15, R16,
  input  logic [Datawidth-1:0] R20, R21, R22, R23, R24, R25, R26,
  input  logic [Datawidth-1:0] R30, R31, R32, R33, R34, R35, R36,
  input  logic [Datawidth-1:0] R40, R41, R42, R43, R44, R45, R46,
  input  logic [Datawidth-1:0] R50, R51, R52, R53, R54, R55, R56,
  input  logic [Datawidth-1:0] R60, R61, R62, R63, R64, R65, R66,
  output logic [Datawidth-1:0] Out,
  output logic                 Valid_OUT,
  output logic                 End_Row
);
  localparam int DW = Datawidth;
  localparam int CW = (IMG_Width > 1) ? $clog2(IMG_Width) : 1;
  localparam int PW = DW + 18;  // holds max_sum*RECIP + ROUND
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_Width - 1);

  typedef logic [DW+2:0] row_t;
  typedef logic [DW+3:0] pair_t;
  typedef logic [DW+5:0] tot_t;
  typedef logic [PW-1:0] prod_t;

  logic [KERNEL-1:0][KERNEL*DW-1:0] row_px;
  row_t  [KERNEL-1:0]               row_sum;

  assign row_px[0] = {R06, R05, R04, R03, R02, R01, R00};
  assign row_px[1] = {R16, R15, R14, R13, R12, R11, R10};
  assign row_px[2] = {R26, R25, R24, R23, R22, R21, R20};
  assign row_px[3] = {R36, R35, R34, R33, R32, R31, R30};
  assign row_px[4] = {R46, R45, R44, R43, R42, R41, R40};
  assign row_px[5] = {R56, R55, R54, R53, R52, R51, R50};
  assign row_px[6] = {R66, R65, R64, R63, R62, R61, R60};

  // Stage 1
  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    row_sum_7 #(.DW(DW)) u_row (
      .clk_i (CLK),
      .clr_i (CLR),
      .px_i  (row_px[r]),
      .sum_o (row_sum[r])
    );
  end

  pair_t p01_q, p23_q, p45_q;
  row_t  r6_q;
  tot_t  tot_q, tot_d;
  prod_t prod_d;
  logic [DW-1:0] out_q, out_d;

  logic [CW-1:0] col_q, col_d;
  logic [3:0]    good_q, end_q;
  logic          good_d, end_d;

  always_comb begin
    tot_d  = tot_t'(p01_q) + tot_t'(p23_q) + tot_t'(p45_q) + tot_t'(r6_q);
    prod_d = prod_t'(tot_q) * prod_t'(RECIP) + prod_t'(ROUND);
    if (|prod_d[PW-1:RECIP_SHIFT+DW]) out_d = '1;
    else                              out_d = prod_d[RECIP_SHIFT+DW-1:RECIP_SHIFT];
  end

  // Tags use the pre-increment column so the wrap window is judged correctly.
  always_comb begin
    good_d = Valid_IN && (col_q >= COL_FIRST);
    end_d  = good_d && (col_q == COL_LAST);
    col_d  = col_q;
    if (Valid_IN) col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      p01_q  <= '0;
      p23_q  <= '0;
      p45_q  <= '0;
      r6_q   <= '0;
      tot_q  <= '0;
      out_q  <= '0;
      col_q  <= '0;
      good_q <= '0;
      end_q  <= '0;
    end else begin
      p01_q  <= pair_t'(row_sum[0]) + pair_t'(row_sum[1]);
      p23_q  <= pair_t'(row_sum[2]) + pair_t'(row_sum[3]);
      p45_q  <= pair_t'(row_sum[4]) + pair_t'(row_sum[5]);
      r6_q   <= row_sum[6];
      tot_q  <= tot_d;
      out_q  <= out_d;
      col_q  <= col_d;
      good_q <= {good_q[2:0], good_d};
      end_q  <= {end_q[2:0], end_d};
    end
  end

  assign Out       = out_q;
  assign Valid_OUT = good_q[3];
  assign End_Row   = end_q[3];
endmodule

// File: tb/tb_box_filter_7x7.sv
// Directed and randomized checks of box_filter_7x7 against a queue-based
// model of window tagging and the rounded-mean arithmetic.
module tb_box_filter_7x7;
  localparam int W = 8;

  logic       CLK = 1'b0;
  logic       CLR, Valid_IN;
  logic [7:0] pix [7][7];
  logic [7:0] Out;
  logic       Valid_OUT, End_Row;

  always #5 CLK = ~CLK;

  box_filter_7x7 #(.IMG_Width(W), .Datawidth(8)) dut (
    .CLK(CLK), .CLR(CLR), .Valid_IN(Valid_IN),
    .R00(pix[0][0]), .R01(pix[0][1]), .R02(pix[0][2]), .R03(pix[0][3]), .R04(pix[0][4]), .R05(pix[0][5]), .R06(pix[0][6]),
    .R10(pix[1][0]), .R11(pix[1][1]), .R12(pix[1][2]), .R13(pix[1][3]), .R14(pix[1][4]), .R15(pix[1][5]), .R16(pix[1][6]),
    .R20(pix[2][0]), .R21(pix[2][1]), .R22(pix[2][2]), .R23(pix[2][3]), .R24(pix[2][4]), .R25(pix[2][5]), .R26(pix[2][6]),
    .R30(pix[3][0]), .R31(pix[3][1]), .R32(pix[3][2]), .R33(pix[3][3]), .R34(pix[3][4]), .R35(pix[3][5]), .R36(pix[3][6]),
    .R40(pix[4][0]), .R41(pix[4][1]), .R42(pix[4][2]), .R43(pix[4][3]), .R44(pix[4][4]), .R45(pix[4][5]), .R46(pix[4][6]),
    .R50(pix[5][0]), .R51(pix[5][1]), .R52(pix[5][2]), .R53(pix[5][3]), .R54(pix[5][4]), .R55(pix[5][5]), .R56(pix[5][6]),
    .R60(pix[6][0]), .R61(pix[6][1]), .R62(pix[6][2]), .R63(pix[6][3]), .R64(pix[6][4]), .R65(pix[6][5]), .R66(pix[6][6]),
    .Out(Out), .Valid_OUT(Valid_OUT), .End_Row(End_Row)
  );

  typedef struct { int due; int val; bit eor; } res_t;

  res_t q[$];
  int   checks = 0, failures = 0;
  int   t = 0, col_m = 0;
  int   vo_cnt = 0, er_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic int ref_mean();
    int s = 0;
    int m;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++) s += pix[i][j];
    m = (s * 1337 + 32768) >> 16;
    return (m > 255) ? 255 : m;
  endfunction

  // One clock: update the model with what the DUT sampled, then check outputs.
  task automatic tick();
    res_t r;
    bit   ev = 0, ee = 0;
    int   eo = 0;
    @(posedge CLK);
    t++;
    if (CLR) begin
      q.delete();
      col_m = 0;
    end else if (Valid_IN) begin
      if (col_m >= 6) begin
        r.due = t + 3; r.val = ref_mean(); r.eor = (col_m == W - 1);
        q.push_back(r);
      end
      col_m = (col_m == W - 1) ? 0 : col_m + 1;
    end
    if (q.size() > 0 && q[0].due == t) begin
      ev = 1; ee = q[0].eor; eo = q[0].val;
      void'(q.pop_front());
    end
    #1;
    chk("Valid_OUT", 32'(Valid_OUT), 32'(ev));
    chk("End_Row", 32'(End_Row), 32'(ee));
    if (ev)  chk("Out", 32'(Out), 32'(eo));
    if (CLR) chk("Out_after_clr", 32'(Out), 0);
    vo_cnt += int'(Valid_OUT);
    er_cnt += int'(End_Row);
  endtask

  task automatic rand_pix();
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++) pix[i][j] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++) pix[i][j] = 8'(v);
  endtask

  task automatic idle(input int n);
    Valid_IN = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic feed(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      rand_pix();
      Valid_IN = 1'b1;
      tick();
      if (gap) idle(1);
    end
    Valid_IN = 1'b0;
  endtask

  task automatic pulse();
    Valid_IN = 1'b1;
    tick();
    Valid_IN = 1'b0;
  endtask

  task automatic do_clr();
    Valid_IN = 1'b0;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; Valid_IN = 1'b0; fill(0);
    tick(); tick();
    chk("reset_Out", 32'(Out), 0);
    chk("reset_Valid_OUT", 32'(Valid_OUT), 0);
    chk("reset_End_Row", 32'(End_Row), 0);
    CLR = 1'b0;

    // Uniform 100 at col 6
    feed(6, 0); fill(100); pulse(); idle(3);
    chk("mean100_out", 32'(Out), 100);
    chk("mean100_vld", 32'(Valid_OUT), 1);
    // Uniform 255 at col 7 (row end)
    fill(255); pulse(); idle(3);
    chk("mean255_out", 32'(Out), 255);
    chk("mean255_eor", 32'(End_Row), 1);
    // All zeros at col 6
    feed(6, 0); fill(0); pulse(); idle(3);
    chk("mean0_out", 32'(Out), 0);
    chk("mean0_vld", 32'(Valid_OUT), 1);
    // Ramp 7*i+j at col 6
    feed(7, 0);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++) pix[i][j] = 8'(7 * i + j);
    pulse(); idle(3);
    chk("ramp_out", 32'(Out), 24);

    // 16 back-to-back windows
    do_clr(); vo_cnt = 0; er_cnt = 0;
    feed(16, 0); idle(4);
    chk("b2b_valid_count", 32'(vo_cnt), 4);
    chk("b2b_eor_count", 32'(er_cnt), 2);

    // CLR two cycles after the third good window
    do_clr();
    feed(15, 0); idle(1);
    vo_cnt = 0;
    do_clr(); idle(6);
    chk("clr_flush_count", 32'(vo_cnt), 0);
    feed(6, 0); idle(4);
    chk("clr_restart_none", 32'(vo_cnt), 0);
    feed(1, 0); idle(3);
    chk("clr_restart_first", 32'(vo_cnt), 1);

    // Simultaneous CLR and Valid_IN: window dropped, col stays 0
    do_clr();
    rand_pix(); CLR = 1'b1; Valid_IN = 1'b1; tick(); CLR = 1'b0;
    vo_cnt = 0;
    feed(6, 0); idle(4);
    chk("clr_prio_none", 32'(vo_cnt), 0);
    feed(1, 0); idle(3);
    chk("clr_prio_first", 32'(vo_cnt), 1);

    // Alternating valid/gap across two rows
    do_clr(); vo_cnt = 0; er_cnt = 0;
    feed(16, 1); idle(4);
    chk("gap_valid_count", 32'(vo_cnt), 4);
    chk("gap_eor_count", 32'(er_cnt), 2);

    // Random traffic with occasional CLR
    do_clr();
    for (int n = 0; n < 500; n++) begin
      rand_pix();
      CLR      = ($urandom_range(0, 59) == 0);
      Valid_IN = ($urandom_range(0, 3) != 0);
      tick();
    end
    CLR = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/box_filter_7x7.md
BOX_FILTER_7X7 -- requirements
Module: box_filter_7x7

Interface
REQ-001 SHALL have parameter IMG_Width, default 8, meaning image row length in pixels.
REQ-002 SHALL have parameter Datawidth, default 8, meaning pixel width in bits.
REQ-003 SHALL have one clock and a synchronous, active-high reset: CLK, CLR.
REQ-004 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-005 SHALL have port CLR  input  1  synchronous active-high reset.
REQ-006 SHALL have port Valid_IN  input  1  a complete 7x7 window is present on R00..R66 this cycle.
REQ-007 SHALL have ports R00..R66  input  Datawidth each (49 ports)  window pixels, row 0 oldest, column 6 newest.
REQ-008 SHALL have port Out  output  Datawidth  rounded window mean.
REQ-009 SHALL have port Valid_OUT  output  1  Out holds a valid, non-wrapping window result.
REQ-010 SHALL have port End_Row  output  1  this result is the last one of an image row; only high when Valid_OUT is high.

Function
REQ-011 SHALL keep a column counter col, 0..IMG_Width-1, that increments on each Valid_IN cycle and wraps from IMG_Width-1 to 0.
REQ-012 SHALL tag a window as good only when Valid_IN=1 and col>=6, so windows spanning a row wrap are suppressed.
REQ-013 SHALL tag a good window as row-end when col==IMG_Width-1.
REQ-014 SHALL hold col when Valid_IN=0; gaps in Valid_IN SHALL NOT move column alignment.
REQ-015 Stage 1 SHALL register seven row sums, each 7 pixels wide, at Datawidth+3 bits.
REQ-016 Stage 2 SHALL register three pairwise sums plus the seventh row sum passed through.
REQ-017 Stage 3 SHALL register the full 49-pixel sum at Datawidth+6 bits, with no overflow.
REQ-018 Stage 4 SHALL register Out = (sum*1337 + 32768) >> 16, saturated to 2^Datawidth-1.
REQ-019 SHALL clock data registers every cycle (free-running); a 4-deep tag shift register SHALL carry good and row-end.
REQ-020 SHALL drive Valid_OUT and End_Row from tag stage 4; latency from Valid_IN to Valid_OUT SHALL be exactly 4 cycles.
REQ-021 SHALL accept back-to-back Valid_IN every cycle: throughput 1 result/cycle, no backpressure.
REQ-022 When Valid_IN=1 on the col wrap, the counter SHALL wrap and the window SHALL be evaluated using pre-increment col.

Reset
REQ-023 On CLR=1 at a rising edge: col=0, all tags=0, all data registers=0, so Out=0, Valid_OUT=0, End_Row=0 on the next cycle.
REQ-024 CLR asserted mid-stream SHALL discard every in-flight result; no Valid_OUT pulse SHALL appear for windows accepted before CLR.
REQ-025 CLR SHALL take priority over a simultaneous Valid_IN; that window SHALL be dropped and col SHALL stay 0.

Structure
REQ-026 SHALL keep the constants KERNEL=7, RECIP=1337, RECIP_SHIFT=16 and ROUND=32768 in the shared project constants package/include.
REQ-027 SHALL use one sub-module, row_sum_7: a registered 7-input adder, instantiated 7 times for stage 1.
REQ-028 SHALL need no FSM beyond the column counter and tag pipeline; the target size is about 150-250 lines of RTL.

Verification
REQ-029 All 49 pixels=100, Valid_IN pulsed with col=6 -> Out=100, Valid_OUT=1 exactly 4 cycles later.
REQ-030 All pixels=255 -> Out=255 (sum 12495, no saturation overflow); all pixels=0 -> Out=0.
REQ-031 Pixels Rij=7*i+j (0..48) -> sum 1176 -> Out=24.
REQ-032 IMG_Width=8, 16 consecutive Valid_IN from reset -> Valid_OUT high for cols 6,7 of each row (4 pulses); End_Row high on the col-7 pulses only.
REQ-033 CLR pulsed 2 cycles after 3 good windows -> zero Valid_OUT pulses afterwards; col restarts at 0 and the next good result is at the 7th Valid_IN.
REQ-034 Valid_IN toggling 1,0,1,0 across a row -> same Valid_OUT/End_Row pattern as REQ-032, each delayed 4 cycles from its Valid_IN.
